// File: rtl/flag_latch_ctrl.sv
// flag_latch_ctrl
// Sequencer and round-robin arbiter that shares one bank of level-sensitive
// SR flag latches among several requesters. Each serviced request runs a
// SETUP / PULSE / HOLD sequence so S and R are stable whenever the bank
// enable is high.
//
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - asynchronous active-low reset
//   req      - per-requester request level
//   req_op   - per-requester operation (1 = set flag, 0 = clear flag)
//   req_idx  - per-requester flag index, requester k at [k*IW +: IW]
//   grant    - one-hot, one-cycle completion pulse
//   err      - pulses with grant when the serviced index is >= NFLAG
//   busy     - high whenever a sequence is in progress
//   lat_s    - S inputs of the latch bank
//   lat_r    - R inputs of the latch bank
//   lat_en   - common enable of the latch bank
module flag_latch_ctrl #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IW    = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_op,
  input  logic [NREQ*IW-1:0] req_idx,
  output logic [NREQ-1:0]    grant,
  output logic               err,
  output logic               busy,
  output logic [NFLAG-1:0]   lat_s,
  output logic [NFLAG-1:0]   lat_r,
  output logic               lat_en
);

  localparam int WW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t          state_r;
  logic [WW-1:0]   rr_ptr_r;
  logic [WW-1:0]   winner_r;
  logic            oor_r;

  logic            found_s;
  logic [WW-1:0]   pick_s;
  logic [WW:0]     cand_s;
  logic            pick_op_s;
  logic [IW-1:0]   pick_idx_s;
  logic [NFLAG-1:0] pick_mask_s;

  // One-hot decode of a flag index; indices >= NFLAG decode to all zeros,
  // which is what keeps out-of-range requests from touching any latch.
  function automatic logic [NFLAG-1:0] flag_decode(input logic [IW-1:0] idx);
    logic [NFLAG-1:0] m;
    m = {NFLAG{1'b0}};
    for (int i = 0; i < NFLAG; i++) begin
      m[i] = (idx == IW'(i));
    end
    return m;
  endfunction

  // Round-robin successor of a requester number.
  function automatic logic [WW-1:0] next_ptr(input logic [WW-1:0] p);
    logic [WW-1:0] n;
    if (p == WW'(NREQ - 1)) begin
      n = {WW{1'b0}};
    end else begin
      n = p + {{(WW-1){1'b0}}, 1'b1};
    end
    return n;
  endfunction

  // Round-robin winner search starting at rr_ptr_r, wrapping upward.
  always_comb begin
    found_s = 1'b0;
    pick_s  = rr_ptr_r;
    cand_s  = {(WW+1){1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      cand_s = {1'b0, rr_ptr_r} + (WW+1)'(i);
      if (cand_s >= (WW+1)'(NREQ)) begin
        cand_s = cand_s - (WW+1)'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req[cand_s[WW-1:0]]) begin
        found_s = 1'b1;
        pick_s  = cand_s[WW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Operation, index and S/R mask of the current round-robin winner.
  always_comb begin
    pick_op_s   = req_op[pick_s];
    pick_idx_s  = req_idx[pick_s*IW +: IW];
    pick_mask_s = flag_decode(pick_idx_s);
  end

  // Sequencer FSM; every output is a register written here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      rr_ptr_r <= {WW{1'b0}};
      winner_r <= {WW{1'b0}};
      oor_r    <= 1'b0;
      grant    <= {NREQ{1'b0}};
      err      <= 1'b0;
      busy     <= 1'b0;
      lat_s    <= {NFLAG{1'b0}};
      lat_r    <= {NFLAG{1'b0}};
      lat_en   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          grant  <= {NREQ{1'b0}};
          err    <= 1'b0;
          lat_en <= 1'b0;
          if (found_s) begin
            // S/R are driven here, one full cycle before lat_en rises.
            winner_r <= pick_s;
            oor_r    <= (pick_idx_s > IW'(NFLAG - 1));
            lat_s    <= pick_op_s ? pick_mask_s : {NFLAG{1'b0}};
            lat_r    <= pick_op_s ? {NFLAG{1'b0}} : pick_mask_s;
            busy     <= 1'b1;
            state_r  <= SETUP;
          end else begin
            lat_s    <= {NFLAG{1'b0}};
            lat_r    <= {NFLAG{1'b0}};
            busy     <= 1'b0;
            state_r  <= IDLE;
          end
        end
        SETUP: begin
          lat_en  <= 1'b1;
          state_r <= PULSE;
        end
        PULSE: begin
          // lat_en falls while S/R stay put; completion is reported now.
          lat_en   <= 1'b0;
          grant    <= {{(NREQ-1){1'b0}}, 1'b1} << winner_r;
          err      <= oor_r;
          rr_ptr_r <= next_ptr(winner_r);
          state_r  <= HOLD;
        end
        HOLD: begin
          grant   <= {NREQ{1'b0}};
          err     <= 1'b0;
          busy    <= 1'b0;
          lat_s   <= {NFLAG{1'b0}};
          lat_r   <= {NFLAG{1'b0}};
          lat_en  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          grant   <= {NREQ{1'b0}};
          err     <= 1'b0;
          busy    <= 1'b0;
          lat_s   <= {NFLAG{1'b0}};
          lat_r   <= {NFLAG{1'b0}};
          lat_en  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flag_latch_ctrl.sv
module tb_flag_latch_ctrl;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [3:0]  req_op;
  logic [11:0] req_idx;

  logic [3:0]  grant;
  logic        err;
  logic        busy;
  logic [7:0]  lat_s;
  logic [7:0]  lat_r;
  logic        lat_en;

  logic [3:0]  grant6;
  logic        err6;
  logic        busy6;
  logic [5:0]  lat_s6;
  logic [5:0]  lat_r6;
  logic        lat_en6;

  // Models of the two latch banks, updated from sampled DUT outputs.
  logic [7:0]  bank;
  logic [5:0]  bank6;

  int n_cmp;
  int n_err;

  logic       track_ok;
  logic       prev_en;
  logic [7:0] prev_s;
  logic [7:0] prev_r;

  flag_latch_ctrl #(.NREQ(4), .NFLAG(8), .IW(3)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_op(req_op), .req_idx(req_idx),
    .grant(grant), .err(err), .busy(busy), .lat_s(lat_s), .lat_r(lat_r), .lat_en(lat_en)
  );

  flag_latch_ctrl #(.NREQ(4), .NFLAG(6), .IW(3)) dut6 (
    .clk(clk), .reset_n(reset_n), .req(req), .req_op(req_op), .req_idx(req_idx),
    .grant(grant6), .err(err6), .busy(busy6), .lat_s(lat_s6), .lat_r(lat_r6), .lat_en(lat_en6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  op;
    logic [11:0] idx;
    logic [3:0]  grant;
    logic [7:0]  s;
    logic [7:0]  r;
    logic [7:0]  bank;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [11:0] pidx(input int k, input logic [2:0] v);
    logic [11:0] t;
    t = 12'h000;
    t[k*3 +: 3] = v;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: sample at the falling edge, check bank invariants, update latch models.
  task automatic tick();
    @(negedge clk);
    chk("s_and_r_zero", 32'(lat_s & lat_r), 32'h0);
    chk("sr_onehot0", 32'($countones(lat_s | lat_r) <= 1), 32'h1);
    if (track_ok && (lat_en !== prev_en)) begin
      chk("s_stable_at_en_edge", 32'(lat_s), 32'(prev_s));
      chk("r_stable_at_en_edge", 32'(lat_r), 32'(prev_r));
    end
    if (lat_en === 1'b1) bank = (bank | lat_s) & ~lat_r;
    if (lat_en6 === 1'b1) bank6 = (bank6 | lat_s6) & ~lat_r6;
    prev_en  = lat_en;
    prev_s   = lat_s;
    prev_r   = lat_r;
    track_ok = 1'b1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    track_ok = 1'b0;
    tick();
    tick();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_lat_s", 32'(lat_s), 32'h0);
    chk("rst_lat_r", 32'(lat_r), 32'h0);
    chk("rst_lat_en", 32'(lat_en), 32'h0);
    reset_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    req = v.req; req_op = v.op; req_idx = v.idx;
    tick();                                   // cycle 1: SETUP
    req = 4'b0000;
    chk("v_c1_lat_s", 32'(lat_s), 32'(v.s));
    chk("v_c1_lat_r", 32'(lat_r), 32'(v.r));
    chk("v_c1_lat_en", 32'(lat_en), 32'h0);
    chk("v_c1_busy", 32'(busy), 32'h1);
    chk("v_c1_grant", 32'(grant), 32'h0);
    tick();                                   // cycle 2: PULSE
    chk("v_c2_lat_en", 32'(lat_en), 32'h1);
    chk("v_c2_lat_s", 32'(lat_s), 32'(v.s));
    chk("v_c2_grant", 32'(grant), 32'h0);
    tick();                                   // cycle 3: HOLD
    chk("v_c3_lat_en", 32'(lat_en), 32'h0);
    chk("v_c3_grant", 32'(grant), 32'(v.grant));
    chk("v_c3_err", 32'(err), 32'h0);
    chk("v_c3_lat_r", 32'(lat_r), 32'(v.r));
    tick();                                   // cycle 4: IDLE
    chk("v_c4_busy", 32'(busy), 32'h0);
    chk("v_c4_grant", 32'(grant), 32'h0);
    chk("v_c4_lat_s", 32'(lat_s), 32'h0);
    chk("v_c4_lat_r", 32'(lat_r), 32'h0);
    chk("v_bank", 32'(bank), 32'(v.bank));
  endtask

  initial begin
    logic [3:0] rr_exp [5];
    logic [3:0] gval [5];
    int         gcyc [5];
    int         ng;
    logic [5:0] bank6_before;

    n_cmp = 0; n_err = 0;
    bank = 8'h00; bank6 = 6'h00;
    track_ok = 1'b0; prev_en = 1'b0; prev_s = 8'h00; prev_r = 8'h00;
    reset_n = 1'b0; req = 4'b0000; req_op = 4'b0000; req_idx = 12'h000;

    vecs[0] = '{4'b0001, 4'b0001, pidx(0, 3'd5), 4'b0001, 8'h20, 8'h00, 8'h20};
    vecs[1] = '{4'b0010, 4'b0010, pidx(1, 3'd2), 4'b0010, 8'h04, 8'h00, 8'h24};
    vecs[2] = '{4'b0010, 4'b0000, pidx(1, 3'd2), 4'b0010, 8'h00, 8'h04, 8'h20};
    vecs[3] = '{4'b1000, 4'b1000, pidx(3, 3'd0), 4'b1000, 8'h01, 8'h00, 8'h21};
    vecs[4] = '{4'b0100, 4'b0100, pidx(2, 3'd7), 4'b0100, 8'h80, 8'h00, 8'hA1};
    vecs[5] = '{4'b0100, 4'b0000, pidx(2, 3'd5), 4'b0100, 8'h00, 8'h20, 8'h81};
    vecs[6] = '{4'b0001, 4'b0000, pidx(0, 3'd0), 4'b0001, 8'h00, 8'h01, 8'h80};

    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

    // Reset state, then single-requester table (includes set/clear of flag 2).
    do_reset();
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Round-robin fairness with all four requesting continuously from reset.
    req = 4'b1111; req_op = 4'b1111;
    req_idx = pidx(0, 3'd0) | pidx(1, 3'd1) | pidx(2, 3'd2) | pidx(3, 3'd3);
    do_reset();
    ng = 0;
    for (int c = 1; c <= 40 && ng < 5; c++) begin
      tick();
      if (grant != 4'b0000) begin
        gval[ng] = grant;
        gcyc[ng] = c;
        ng++;
      end
    end
    req = 4'b0000;
    chk("rr_grant_count", 32'(ng), 32'd5);
    if (ng > 0) chk("rr_first_latency", 32'(gcyc[0]), 32'd3);
    for (int k = 0; k < ng; k++) chk("rr_grant_order", 32'(gval[k]), 32'(rr_exp[k]));
    for (int k = 1; k < ng; k++) chk("rr_grant_gap", 32'(gcyc[k] - gcyc[k-1]), 32'd4);
    tick(); tick(); tick(); tick();

    // Opposing set (req 0) and clear (req 3) of flag 7 with rr_ptr back at 0.
    do_reset();
    req = 4'b1001; req_op = 4'b0001;
    req_idx = pidx(0, 3'd7) | pidx(3, 3'd7);
    tick();
    req = 4'b1000;                            // requester 0 already captured
    tick(); tick();
    chk("opp_first_grant", 32'(grant), 32'h1);
    tick();
    chk("opp_bank7_after_set", 32'(bank[7]), 32'h1);
    tick(); tick(); tick();
    req = 4'b0000;
    chk("opp_second_grant", 32'(grant), 32'h8);
    chk("opp_second_lat_r", 32'(lat_r), 32'h80);
    tick();
    chk("opp_bank7_final", 32'(bank[7]), 32'h0);

    // Out-of-range index on the NFLAG=6 instance.
    bank6_before = bank6;
    req = 4'b0001; req_op = 4'b0001; req_idx = pidx(0, 3'd7);
    for (int c = 1; c <= 3; c++) begin
      tick();
      req = 4'b0000;
      chk("oor_lat_s6", 32'(lat_s6), 32'h0);
      chk("oor_lat_r6", 32'(lat_r6), 32'h0);
    end
    chk("oor_grant6", 32'(grant6), 32'h1);
    chk("oor_err6", 32'(err6), 32'h1);
    chk("oor_err_in_range", 32'(err), 32'h0);
    tick();
    chk("oor_err6_clears", 32'(err6), 32'h0);
    chk("oor_bank6_unchanged", 32'(bank6), 32'(bank6_before));

    // Reset asserted during PULSE, then a pending request from requester 2.
    req = 4'b0001; req_op = 4'b0001; req_idx = pidx(0, 3'd3);
    tick();
    req = 4'b0000;
    tick();
    chk("mid_in_pulse", 32'(lat_en), 32'h1);
    #2;
    reset_n  = 1'b0;
    track_ok = 1'b0;
    #1;
    chk("mid_async_lat_en", 32'(lat_en), 32'h0);
    chk("mid_async_busy", 32'(busy), 32'h0);
    chk("mid_async_lat_s", 32'(lat_s), 32'h0);
    chk("mid_async_lat_r", 32'(lat_r), 32'h0);
    req = 4'b0100; req_op = 4'b0100; req_idx = pidx(2, 3'd6);
    tick();
    chk("mid_no_grant_in_reset", 32'(grant), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    req = 4'b0000;
    chk("mid_after_c1_lat_s", 32'(lat_s), 32'h40);
    chk("mid_after_c1_grant", 32'(grant), 32'h0);
    tick();
    chk("mid_after_c2_grant", 32'(grant), 32'h0);
    tick();
    chk("mid_after_grant", 32'(grant), 32'h4);
    tick();
    chk("mid_after_bank6", 32'(bank[6]), 32'h1);
    chk("mid_after_busy", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
